// File: rtl/alu_sequencer.sv
// alu_sequencer: issue side of the ALU interface.
// Accepts one instruction word ({opcode, Rd, Ra, Rb}) over a valid/ready
// handshake. It reads Ra/Rb from the register file, drives A/B/Sel into the
// combinational ALU for one cycle, captures Q and writes it back to Rd.
// One instruction takes four cycles: IDLE, DECODE, EXECUTE, WRITEBACK.
// Optional build macro: ALU_SEQ_FLAGS_EN adds ZeroFlag/NegFlag outputs that
// are captured from Q at write-back.
//
// Handshake: an instruction transfers on a rising edge where both InstrValid
// and InstrReady are high. InstrReady is high only in IDLE and does not
// depend on InstrValid. While InstrReady is low, InstrValid is ignored.
module alu_sequencer #(
  parameter int DATA_W  = 16,
  parameter int OPC_MAX = 7
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              InstrValid,
  output logic              InstrReady,
  input  logic [15:0]       Instr,
  output logic [3:0]        RdAddrA,
  output logic [3:0]        RdAddrB,
  input  logic [DATA_W-1:0] RdDataA,
  input  logic [DATA_W-1:0] RdDataB,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        Sel,
  input  logic [DATA_W-1:0] Q,
  output logic              WrEn,
  output logic [3:0]        WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic              Done,
  output logic              IllegalOp,
  output logic [1:0]        StateDbg
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              ZeroFlag,
  output logic              NegFlag
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] OPC_MAX_L = 4'(OPC_MAX);

  state_t              state_q, state_d;
  logic [15:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [2:0]          sel_q, sel_d;
  logic [3:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                illegal_q, illegal_d;
  logic                opc_illegal;

  // The latched opcode is illegal when it exceeds the highest legal opcode.
  assign opc_illegal = (instr_q[15:12] > OPC_MAX_L);

  // Next-state and datapath-capture decisions for each FSM state.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (InstrValid) begin
          instr_d = Instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (opc_illegal) begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end else begin
          a_d     = RdDataA;
          b_d     = RdDataB;
          sel_d   = instr_q[14:12];
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        wr_data_d = Q;
        wr_addr_d = instr_q[11:8];
        state_d   = WRITEBACK;
      end
      WRITEBACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any instruction in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q;
  logic neg_q;

  // Flags sample Q on the same edge that captures the write-back data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state_q == EXECUTE) begin
      zero_q <= (Q == '0);
      neg_q  <= Q[DATA_W-1];
    end
  end

  assign ZeroFlag = zero_q;
  assign NegFlag  = neg_q;
`endif

  // Read addresses come straight from the instruction latched at accept.
  assign RdAddrA    = instr_q[7:4];
  assign RdAddrB    = instr_q[3:0];
  assign A          = a_q;
  assign B          = b_q;
  assign Sel        = sel_q;
  assign WrAddr     = wr_addr_q;
  assign WrData     = wr_data_q;
  assign IllegalOp  = illegal_q;
  assign InstrReady = (state_q == IDLE);
  assign WrEn       = (state_q == WRITEBACK);
  assign Done       = (state_q == WRITEBACK);
  assign StateDbg   = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: register-file and ALU models around the DUT,
// a table of single-instruction vectors and directed multi-cycle sequences.
module tb_alu_sequencer;

  localparam int DATA_W = 16;

  logic              Clk;
  logic              Reset_n;
  logic              InstrValid;
  logic              InstrReady;
  logic [15:0]       Instr;
  logic [3:0]        RdAddrA, RdAddrB;
  logic [DATA_W-1:0] RdDataA, RdDataB;
  logic [DATA_W-1:0] A, B, Q;
  logic [2:0]        Sel;
  logic              WrEn;
  logic [3:0]        WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              Done;
  logic              IllegalOp;
  logic [1:0]        StateDbg;
`ifdef ALU_SEQ_FLAGS_EN
  logic              ZeroFlag, NegFlag;
`endif

  alu_sequencer #(.DATA_W(DATA_W), .OPC_MAX(7)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdDataA(RdDataA), .RdDataB(RdDataB),
    .A(A), .B(B), .Sel(Sel), .Q(Q),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Done(Done), .IllegalOp(IllegalOp), .StateDbg(StateDbg)
`ifdef ALU_SEQ_FLAGS_EN
    , .ZeroFlag(ZeroFlag), .NegFlag(NegFlag)
`endif
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- register file and ALU models ----------------
  logic [DATA_W-1:0] regs [16];
  logic              ld_en;
  logic [3:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;
  int                wr_count;

  assign RdDataA = regs[RdAddrA];
  assign RdDataB = regs[RdAddrB];

  always @(posedge Clk) begin
    if (WrEn) regs[WrAddr] <= WrData;
    if (ld_en) regs[ld_addr] <= ld_data;
  end

  initial wr_count = 0;
  always @(posedge Clk) if (WrEn) wr_count <= wr_count + 1;

  always_comb begin
    Q = '0;
    case (Sel)
      3'd0: Q = '0;
      3'd1: Q = A + B;
      3'd2: Q = A - B;
      3'd3: Q = A;
      3'd4: Q = A ^ B;
      3'd5: Q = A | B;
      3'd6: Q = A & B;
      3'd7: Q = A + 16'd1;
      default: Q = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fail;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge of a write-back cycle.
  task automatic expect_wb();
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none", WrAddr, WrData);
    end else begin
      e = exp_q.pop_front();
      check("wb_addr_data", {12'd0, WrAddr, WrData}, {12'd0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [3:0] addr, input logic [DATA_W-1:0] data);
    @(negedge Clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge Clk);
    ld_en = 1'b0;
  endtask

  // Returns at the negedge of the DECODE cycle.
  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    @(negedge Clk);
    while (!InstrReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      InstrValid = 1'b1;
      Instr = ins;
      @(negedge Clk);
      InstrValid = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0]       instr;
    logic [DATA_W-1:0] va;
    logic [DATA_W-1:0] vb;
    logic [2:0]        sel;
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              neg;
  } vec_t;

  vec_t vecs [10];
  logic [15:0] hs_instr [3];
  logic [19:0] hs_exp [3];

  initial begin
    int k, last, wc0;
    n_checks = 0; n_fail = 0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    InstrValid = 1'b0; Instr = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;

    vecs[0] = '{16'h0412, 16'd15, 16'd16, 3'd0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1412, 16'd15, 16'd16, 3'd1, 16'd31,   1'b0, 1'b0};
    vecs[2] = '{16'h2412, 16'd15, 16'd16, 3'd2, 16'hFFFF, 1'b0, 1'b1};
    vecs[3] = '{16'h3412, 16'd15, 16'd16, 3'd3, 16'd15,   1'b0, 1'b0};
    vecs[4] = '{16'h4412, 16'd15, 16'd16, 3'd4, 16'd31,   1'b0, 1'b0};
    vecs[5] = '{16'h5412, 16'd15, 16'd16, 3'd5, 16'd31,   1'b0, 1'b0};
    vecs[6] = '{16'h6412, 16'd15, 16'd16, 3'd6, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h7412, 16'd15, 16'd16, 3'd7, 16'd16,   1'b0, 1'b0};
    vecs[8] = '{16'h1312, 16'd15, 16'd16, 3'd1, 16'd31,   1'b0, 1'b0};
    vecs[9] = '{16'h1111, 16'h8000, 16'h8000, 3'd1, 16'h0000, 1'b1, 1'b0};

    hs_instr[0] = 16'h1612; hs_exp[0] = {4'd6, 16'd31};
    hs_instr[1] = 16'h2712; hs_exp[1] = {4'd7, 16'hFFFF};
    hs_instr[2] = 16'h3812; hs_exp[2] = {4'd8, 16'd15};

    // ---- reset ----
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_ready", {31'd0, InstrReady}, 32'd1);
    check("rst_wren", {31'd0, WrEn}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_illegal", {31'd0, IllegalOp}, 32'd0);
    check("rst_a_b_sel", {13'd0, A, Sel}, 32'd0);
    check("rst_wr", {12'd0, WrAddr, WrData}, 32'd0);
    check("rst_rdaddr", {24'd0, RdAddrA, RdAddrB}, 32'd0);
    check("rst_state", {30'd0, StateDbg}, 32'd0);
    Reset_n = 1'b1;

    // ---- table-driven single instructions ----
    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].instr[7:4], vecs[i].va);
      preload(vecs[i].instr[3:0], vecs[i].vb);
      issue(vecs[i].instr);
      check("dec_state", {30'd0, StateDbg}, 32'd1);
      check("dec_ready", {31'd0, InstrReady}, 32'd0);
      check("dec_rdaddr", {24'd0, RdAddrA, RdAddrB}, {24'd0, vecs[i].instr[7:0]});
      @(negedge Clk);
      check("exe_sel", {29'd0, Sel}, {29'd0, vecs[i].sel});
      check("exe_a_b", {A, B}, {vecs[i].va, vecs[i].vb});
      check("exe_wren", {31'd0, WrEn}, 32'd0);
      @(negedge Clk);
      check("wb_wren_done", {30'd0, WrEn, Done}, 32'd3);
      check("wb_addr", {28'd0, WrAddr}, {28'd0, vecs[i].instr[11:8]});
      check("wb_data", {16'd0, WrData}, {16'd0, vecs[i].data});
`ifdef ALU_SEQ_FLAGS_EN
      check("wb_flags", {30'd0, ZeroFlag, NegFlag}, {30'd0, vecs[i].zero, vecs[i].neg});
`endif
      @(negedge Clk);
      check("post_wren_done", {30'd0, WrEn, Done}, 32'd0);
      check("post_ready", {31'd0, InstrReady}, 32'd1);
    end

    // ---- handshake: InstrValid held high across back-to-back instructions ----
    preload(4'd1, 16'd15);
    preload(4'd2, 16'd16);
    k = 0; last = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (WrEn) expect_wb();
      if (InstrReady) begin
        if (k < 3) begin
          if (k > 0) check("accept_spacing", c - last, 32'd4);
          last = c;
          Instr = hs_instr[k];
          InstrValid = 1'b1;
          exp_q.push_back(hs_exp[k]);
          k++;
        end else begin
          InstrValid = 1'b0;
          break;
        end
      end
    end
    InstrValid = 1'b0;
    check("hs_accepts", k, 32'd3);
    check("hs_pending", exp_q.size(), 32'd0);

    // ---- illegal opcode, then a legal instruction ----
    preload(4'd1, 16'd15);
    preload(4'd2, 16'd16);
    wc0 = wr_count;
    issue(16'h9312);
    check("ill_dec_flag", {31'd0, IllegalOp}, 32'd0);
    @(negedge Clk);
    check("ill_flag", {31'd0, IllegalOp}, 32'd1);
    check("ill_state", {30'd0, StateDbg}, 32'd0);
    check("ill_ready", {31'd0, InstrReady}, 32'd1);
    check("ill_wren_done", {30'd0, WrEn, Done}, 32'd0);
    check("ill_hold_sel_a", {13'd0, Sel, A}, {13'd0, 3'd3, 16'd15});
    repeat (2) @(negedge Clk);
    check("ill_no_write", wr_count - wc0, 32'd0);
    exp_q.push_back({4'd5, 16'd16});
    issue(16'h7511);
    @(negedge Clk);
    check("inc_sel", {29'd0, Sel}, 32'd7);
    @(negedge Clk);
    check("inc_done", {31'd0, Done}, 32'd1);
    if (WrEn) expect_wb();
    else check("inc_wren", 32'd0, 32'd1);
    @(negedge Clk);
    check("ill_sticky", {31'd0, IllegalOp}, 32'd1);

    // ---- reset during EXECUTE ----
    wc0 = wr_count;
    issue(16'h1312);
    @(negedge Clk);
    check("mid_state_exec", {30'd0, StateDbg}, 32'd2);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_wren", {31'd0, WrEn}, 32'd0);
    check("mid_rst_ready", {31'd0, InstrReady}, 32'd1);
    check("mid_rst_a_b", {A, B}, 32'd0);
    check("mid_rst_sel_wr", {9'd0, Sel, WrAddr, WrData}, 32'd0);
    check("mid_rst_illegal", {31'd0, IllegalOp}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    check("mid_no_write", wr_count - wc0, 32'd0);
    check("mid_post_ready", {31'd0, InstrReady}, 32'd1);
    exp_q.push_back({4'd3, 16'd31});
    issue(16'h1312);
    @(negedge Clk);
    @(negedge Clk);
    if (WrEn) expect_wb();
    else check("fresh_wren", 32'd0, 32'd1);
    @(negedge Clk);
    check("final_pending", exp_q.size(), 32'd0);
    check("final_reg3", {16'd0, regs[3]}, 32'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
